// File: rtl/aibio_pi_phsel_pkg.sv
// Shared types for the RX DLL phase-interpolator phase-select controller.
// Holds the FSM state encoding and the shortest-path direction helper.
package aibio_pi_phsel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_XOFF,
        ST_XSEL,
        ST_XON,
        ST_SETTLE
    } phsel_st_e;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DN
    } phsel_dir_e;

    // A forward distance of exactly half the ring resolves upward.
    function automatic phsel_dir_e phsel_dir(input int cur, input int tgt, input int nph);
        int d;
        d = (tgt - cur + nph) % nph;
        if (d == 0) begin
            return DIR_NONE;
        end else if (d <= nph / 2) begin
            return DIR_UP;
        end else begin
            return DIR_DN;
        end
    endfunction

endpackage

// File: rtl/aibio_pi_phsel_dec.sv
// Phase code to select decode: per-quarter one-hot stg1 and one-hot stg2 quarter enable.
// Latency: combinational. Backpressure: none, the controller registers the result.
// Stage-1 bit index equals the code itself because each quarter owns four consecutive phases.
module aibio_pi_phsel_dec #(
    parameter int NQ     = 4,
    parameter int CODE_W = $clog2(4 * NQ)
) (
    input  logic [CODE_W-1:0] code,
    output logic [4*NQ-1:0]   stg1,
    output logic [NQ-1:0]     stg2
);

    always_comb begin
        stg1 = '0;
        stg2 = '0;
        stg1[code] = 1'b1;
        stg2[code[CODE_W-1:2]] = 1'b1;
    end

endmodule

// File: rtl/aibio_pi_phsel_ctrl.sv
// Phase-select controller: walks the PI phase one step at a time toward a target code.
// Latency: ack one cycle after accept; per step 1+SETTLE_CYC cycles, crossings add XOFF/XSEL/XON.
// Backpressure: new codes are ignored (no ack) while busy; a held valid is taken on return to idle.
module aibio_pi_phsel_ctrl
    import aibio_pi_phsel_pkg::*;
#(
    parameter int  NQ         = 4,
    parameter int  SETTLE_CYC = 4,
    parameter int  GAP_CYC    = 2,
    localparam int NPH        = 4 * NQ,
    localparam int CODE_W     = $clog2(NPH)
) (
    input  logic              i_clk,
    input  logic              i_rstb,
    input  logic              vddcq,
    input  logic              vss,
    input  logic              i_code_vld,
    input  logic [CODE_W-1:0] i_phase_code,
    output logic              o_code_ack,
    output logic              o_busy,
    output logic [CODE_W-1:0] o_cur_code,
    output logic [4*NQ-1:0]   o_clkphsel_stg1,
    output logic [NQ-1:0]     o_clkphsel_stg2
);

    localparam int CNT_MAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    // stg2 stays low through XOFF plus the XSEL cycle, so XOFF itself is one cycle shorter than the gap.
    localparam logic [CNT_W-1:0]  XOFF_LAST   = CNT_W'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);
    localparam logic [CODE_W-1:0] CODE_MAX    = CODE_W'(NPH - 1);

    phsel_st_e         st_q, st_d;
    logic [CODE_W-1:0] tgt_q, tgt_d;
    logic [CODE_W-1:0] cur_q, cur_d;
    logic [4*NQ-1:0]   stg1_q, stg1_d;
    logic [NQ-1:0]     stg2_q, stg2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;

    phsel_dir_e        dir;
    logic [CODE_W-1:0] nxt_code;
    logic [CODE_W-1:0] dec_code;
    logic [4*NQ-1:0]   dec_stg1;
    logic [NQ-1:0]     dec_stg2;

    logic unused_supply;
    assign unused_supply = vddcq ^ vss;

    always_comb begin
        dir      = phsel_dir(32'(cur_q), 32'(tgt_q), NPH);
        nxt_code = cur_q;
        if (dir == DIR_UP) begin
            nxt_code = (cur_q == CODE_MAX) ? '0 : cur_q + 1'b1;
        end else if (dir == DIR_DN) begin
            nxt_code = (cur_q == '0) ? CODE_MAX : cur_q - 1'b1;
        end
    end

    // In XSEL the current code has already advanced, so the quarter enable decodes from it.
    assign dec_code = (st_q == ST_XSEL) ? cur_q : nxt_code;

    aibio_pi_phsel_dec #(
        .NQ     (NQ),
        .CODE_W (CODE_W)
    ) u_dec (
        .code (dec_code),
        .stg1 (dec_stg1),
        .stg2 (dec_stg2)
    );

    always_comb begin
        st_d   = st_q;
        tgt_d  = tgt_q;
        cur_d  = cur_q;
        stg1_d = stg1_q;
        stg2_d = stg2_q;
        cnt_d  = cnt_q;
        ack_d  = 1'b0;
        busy_d = busy_q;
        case (st_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (i_code_vld && !busy_q && (i_phase_code <= CODE_MAX)) begin
                    tgt_d  = i_phase_code;
                    ack_d  = 1'b1;
                    busy_d = 1'b1;
                    if (i_phase_code != cur_q) begin
                        st_d = ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                cnt_d = '0;
                if (nxt_code[CODE_W-1:2] == cur_q[CODE_W-1:2]) begin
                    stg1_d = dec_stg1;
                    cur_d  = nxt_code;
                    st_d   = ST_SETTLE;
                end else begin
                    stg2_d = '0;
                    st_d   = ST_XOFF;
                end
            end
            ST_XOFF: begin
                if (cnt_q == XOFF_LAST) begin
                    stg1_d = dec_stg1;
                    cur_d  = nxt_code;
                    st_d   = ST_XSEL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_XSEL: begin
                stg2_d = dec_stg2;
                st_d   = ST_XON;
            end
            ST_XON: begin
                cnt_d = '0;
                st_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    if (cur_q != tgt_q) begin
                        st_d = ST_STEP;
                    end else begin
                        st_d   = ST_IDLE;
                        busy_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            st_q   <= ST_IDLE;
            tgt_q  <= '0;
            cur_q  <= '0;
            stg1_q <= (4*NQ)'(1);
            stg2_q <= NQ'(1);
            cnt_q  <= '0;
            ack_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            tgt_q  <= tgt_d;
            cur_q  <= cur_d;
            stg1_q <= stg1_d;
            stg2_q <= stg2_d;
            cnt_q  <= cnt_d;
            ack_q  <= ack_d;
            busy_q <= busy_d;
        end
    end

    assign o_code_ack      = ack_q;
    assign o_busy          = busy_q;
    assign o_cur_code      = cur_q;
    assign o_clkphsel_stg1 = stg1_q;
    assign o_clkphsel_stg2 = stg2_q;

endmodule

// File: tb/tb_aibio_pi_phsel_ctrl.sv
// Directed and random phase moves; expected ack, path, busy length and final selects go to queues.
// A negedge monitor pops and compares them and checks the crossing/one-hot invariants every cycle.
module tb_aibio_pi_phsel_ctrl;

    typedef struct {
        int         busy;
        logic [3:0] cur;
        logic [15:0] stg1;
        logic [3:0] stg2;
    } exp_done_t;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic        vld = 1'b0;
    logic [3:0]  code = '0;
    logic        ack, busy;
    logic [3:0]  cur;
    logic [15:0] stg1;
    logic [3:0]  stg2;

    logic [3:0]  ack_q[$];
    logic [3:0]  path_q[$];
    exp_done_t   done_q[$];

    int   n_vec = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;
    bit   path_chk = 1'b1;
    logic [3:0] model_cur = '0;

    always #5 clk = ~clk;

    aibio_pi_phsel_ctrl dut (
        .i_clk           (clk),
        .i_rstb          (rstb),
        .vddcq           (1'b1),
        .vss             (1'b0),
        .i_code_vld      (vld),
        .i_phase_code    (code),
        .o_code_ack      (ack),
        .o_busy          (busy),
        .o_cur_code      (cur),
        .o_clkphsel_stg1 (stg1),
        .o_clkphsel_stg2 (stg2)
    );

    // Monitor
    initial begin
        logic        prev_busy;
        logic [3:0]  prev_cur, prev_stg2;
        logic [15:0] prev_stg1, gap_stg1;
        int          busy_cnt, zero_run;
        logic [3:0]  e4;
        exp_done_t   e;
        bit          q_ok;
        prev_busy = 1'b0; prev_cur = '0; prev_stg1 = '0; prev_stg2 = '0;
        gap_stg1 = '0; busy_cnt = 0; zero_run = 0;
        forever begin
            @(negedge clk);
            if (!chk_en) begin
                zero_run = 0;
            end else begin
                if (ack) begin
                    busy_cnt = 0;
                    if (ack_q.size() == 0) begin
                        $display("FAIL unexpected_ack cur=%0d", cur); miscompares++;
                    end else begin
                        e4 = ack_q.pop_front();
                        if (cur !== e4) begin
                            $display("FAIL ack_cur got %0d want %0d", cur, e4); miscompares++;
                        end
                    end
                end
                if (busy) busy_cnt++;
                if (path_chk && cur !== prev_cur) begin
                    if (path_q.size() == 0) begin
                        $display("FAIL unexpected_step got %0d", cur); miscompares++;
                    end else begin
                        e4 = path_q.pop_front();
                        if (cur !== e4) begin
                            $display("FAIL path_step got %0d want %0d", cur, e4); miscompares++;
                        end
                    end
                end
                if (prev_busy && !busy) begin
                    if (done_q.size() == 0) begin
                        $display("FAIL unexpected_done cur=%0d", cur); miscompares++;
                    end else begin
                        e = done_q.pop_front();
                        if (e.busy >= 0 && busy_cnt != e.busy) begin
                            $display("FAIL busy_len got %0d want %0d", busy_cnt, e.busy); miscompares++;
                        end
                        if (cur !== e.cur) begin
                            $display("FAIL final_cur got %0d want %0d", cur, e.cur); miscompares++;
                        end
                        if (stg1 !== e.stg1) begin
                            $display("FAIL final_stg1 got %h want %h", stg1, e.stg1); miscompares++;
                        end
                        if (stg2 !== e.stg2) begin
                            $display("FAIL final_stg2 got %b want %b", stg2, e.stg2); miscompares++;
                        end
                    end
                end
                if (!$onehot0(stg2)) begin
                    $display("FAIL stg2_onehot0 got %b", stg2); miscompares++;
                end
                for (int q = 0; q < 4; q++) begin
                    if (stg2[q]) begin
                        q_ok = $onehot(stg1[4*q +: 4]) && ((stg1 & ~(16'hF << (4*q))) == 16'h0);
                        if (!q_ok) begin
                            $display("FAIL stg1_quarter got %h want onehot in quarter %0d", stg1, q);
                            miscompares++;
                        end
                    end
                end
                if (stg1 !== prev_stg1 && stg2 !== prev_stg2) begin
                    $display("FAIL same_cycle_change stg1 %h->%h stg2 %b->%b", prev_stg1, stg1, prev_stg2, stg2);
                    miscompares++;
                end
                if (stg2 == 4'b0000) begin
                    if (zero_run == 0) gap_stg1 = prev_stg1;
                    zero_run++;
                end else if (zero_run > 0) begin
                    if (zero_run != 2) begin
                        $display("FAIL gap_len got %0d want 2", zero_run); miscompares++;
                    end
                    if (stg1 === gap_stg1) begin
                        $display("FAIL gap_stg1_switch got %h want change from %h", stg1, gap_stg1);
                        miscompares++;
                    end
                    zero_run = 0;
                end
            end
            prev_busy = busy; prev_cur = cur; prev_stg1 = stg1; prev_stg2 = stg2;
        end
    end

    task automatic check_reset(input string tag);
        if (cur !== 4'd0 || stg1 !== 16'h0001 || stg2 !== 4'b0001 || busy !== 1'b0 || ack !== 1'b0) begin
            $display("FAIL %s got cur=%0d stg1=%h stg2=%b busy=%b ack=%b want 0/0001/0001/0/0",
                     tag, cur, stg1, stg2, busy, ack);
            miscompares++;
        end
    endtask

    task automatic apply(input logic [3:0] c, input int len, input logic [31:0] path,
                         input int bcyc, input logic [15:0] s1, input logic [3:0] s2, input bit hold);
        exp_done_t   e;
        logic [31:0] p;
        int          t;
        @(negedge clk);
        ack_q.push_back(model_cur);
        p = path;
        for (int i = 0; i < len; i++) begin
            path_q.push_back(p[3:0]);
            p = p >> 4;
        end
        e.busy = bcyc; e.cur = c; e.stg1 = s1; e.stg2 = s2;
        done_q.push_back(e);
        model_cur = c;
        n_vec++;
        vld = 1'b1; code = c;
        t = 0;
        do begin
            @(negedge clk); t++;
        end while (!ack && t < 20);
        if (!ack) begin
            $display("FAIL ack_timeout code=%0d got ack=0 want 1", c); miscompares++;
        end
        if (hold) code = ~c;
        else vld = 1'b0;
        t = 0;
        while (busy && t < 400) begin
            @(negedge clk); t++;
        end
        if (busy) begin
            $display("FAIL busy_timeout code=%0d got busy=1 want 0", c); miscompares++;
        end
        vld = 1'b0;
    endtask

    initial begin
        int t;
        logic [3:0] r;
        #1 rstb = 1'b0;
        #2 check_reset("reset_values");
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        apply(4'd3,  3, 32'h0000_0321, 15, 16'h0008, 4'b0001, 1'b0);
        apply(4'd5,  2, 32'h0000_0054, 13, 16'h0020, 4'b0010, 1'b0);
        apply(4'd1,  4, 32'h0000_1234, 23, 16'h0002, 4'b0001, 1'b0);
        apply(4'd14, 3, 32'h0000_0EF0, 18, 16'h4000, 4'b1000, 1'b0);
        apply(4'd0,  2, 32'h0000_000F, 13, 16'h0001, 4'b0001, 1'b0);
        apply(4'd8,  8, 32'h8765_4321, 46, 16'h0100, 4'b0100, 1'b0);
        apply(4'd8,  0, 32'h0000_0000,  1, 16'h0100, 4'b0100, 1'b1);
        apply(4'd15, 7, 32'h0FED_CBA9, 38, 16'h8000, 4'b1000, 1'b1);
        apply(4'd7,  8, 32'h7654_3210, 46, 16'h0080, 4'b0010, 1'b0);

        // Reset while the crossing 7->8 has stg2 low.
        chk_en = 1'b0;
        @(negedge clk);
        vld = 1'b1; code = 4'd8;
        t = 0;
        do begin
            @(negedge clk); t++;
        end while (stg2 !== 4'b0000 && t < 20);
        if (stg2 !== 4'b0000) begin
            $display("FAIL xoff_timeout got stg2=%b want 0000", stg2); miscompares++;
        end
        #1 vld = 1'b0; rstb = 1'b0;
        #1 check_reset("reset_mid_xoff");
        @(negedge clk);
        rstb = 1'b1;
        model_cur = 4'd0;
        @(negedge clk);
        chk_en = 1'b1;
        apply(4'd2, 2, 32'h0000_0021, 10, 16'h0004, 4'b0001, 1'b0);

        path_chk = 1'b0;
        for (int i = 0; i < 6; i++) begin
            r = 4'($urandom_range(0, 15));
            apply(r, 0, 32'h0, -1, 16'h0001 << r, 4'b0001 << r[3:2], 1'b0);
        end

        repeat (4) @(negedge clk);
        if (ack_q.size() != 0 || path_q.size() != 0 || done_q.size() != 0) begin
            $display("FAIL queues_drained got ack=%0d path=%0d done=%0d want 0/0/0",
                     ack_q.size(), path_q.size(), done_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
